// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and default parameters for the async-FIFO read-side drain controller.
package fifo_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_TIMEOUT    = 16;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Drains the FIFO one word at a time into a busy-handshaked serial consumer,
// with an acceptance timeout (sticky error) and a delivered-word counter.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  input  logic                  err_clr,
  output logic                  err_timeout,
  output logic [CNT_WIDTH-1:0]  sent_cnt
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Last WAIT_BUSY count before giving up; the error then shows TIMEOUT cycles after SEND.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  state_e                state_q, state_d;
  logic [TW-1:0]         tmo_cnt, tmo_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic [CNT_WIDTH-1:0]  sent_cnt_d;
  logic                  rinc_d, tx_valid_d, err_d, tmo_hit;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q     <= ST_IDLE;
      tmo_cnt     <= '0;
      tx_data     <= '0;
      sent_cnt    <= '0;
      rinc        <= 1'b0;
      tx_valid    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt     <= tmo_cnt_d;
      tx_data     <= tx_data_d;
      sent_cnt    <= sent_cnt_d;
      rinc        <= rinc_d;
      tx_valid    <= tx_valid_d;
      err_timeout <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt;
    tx_data_d  = tx_data;
    sent_cnt_d = sent_cnt;
    rinc_d     = 1'b0;
    tx_valid_d = 1'b0;
    tmo_hit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en && !rempty) begin
          rinc_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = rdata;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          sent_cnt_d = sent_cnt + CNT_WIDTH'(1);
          state_d    = ST_WAIT_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
          if (tmo_cnt == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear wins over a simultaneous timeout.
    if (err_clr)      err_d = 1'b0;
    else if (tmo_hit) err_d = 1'b1;
    else              err_d = err_timeout;
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench: small FIFO and busy-consumer models around fifo_rd_ctrl.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n, en, err_clr, tx_busy;
  logic       rinc, tx_valid, err_timeout, rempty;
  logic [7:0] rdata, tx_data;
  logic [3:0] sent_cnt;

  logic [7:0] mem [0:31];
  logic [7:0] log_data [0:63];
  int wp = 0, rp = 0;
  int busy_len = 1, busy_rem = 0;
  int rinc_cnt = 0, txv_cnt = 0, pop_empty = 0;
  int cyc = 0, last_rinc = -1, min_gap = 1000;
  int n_chk = 0, n_fail = 0;
  int base_rinc, base_txv;

  fifo_rd_ctrl #(.DATA_WIDTH(8), .TIMEOUT(16), .CNT_WIDTH(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .err_clr(err_clr), .err_timeout(err_timeout), .sent_cnt(sent_cnt)
  );

  always #5 rclk = ~rclk;

  assign rempty = (rp == wp);
  assign rdata  = mem[rp % 32];

  // FIFO read side plus pop/handshake bookkeeping.
  always @(posedge rclk) begin
    cyc <= cyc + 1;
    if (rinc) begin
      if (rp == wp) pop_empty <= pop_empty + 1;
      else rp <= rp + 1;
      rinc_cnt <= rinc_cnt + 1;
      if (last_rinc >= 0 && (cyc - last_rinc) < min_gap) min_gap <= cyc - last_rinc;
      last_rinc <= cyc;
    end
    if (tx_valid) begin
      log_data[txv_cnt % 64] <= tx_data;
      txv_cnt <= txv_cnt + 1;
    end
  end

  // Consumer: rises the cycle after tx_valid, stays busy busy_len cycles (0 = never).
  initial tx_busy = 1'b0;
  always @(posedge rclk) begin
    if (tx_valid && busy_len > 0) begin
      tx_busy  <= 1'b1;
      busy_rem <= busy_len - 1;
    end else if (busy_rem > 0) begin
      busy_rem <= busy_rem - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp % 32] = d;
    wp = wp + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rrst_n = 1'b0; en = 1'b0; err_clr = 1'b0;
    step(3);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_cnt", 32'(sent_cnt), 32'd0);

    // Two words: 1-cycle then 5-cycle busy.
    push(8'hA5); push(8'h3C);
    rrst_n = 1'b1; en = 1'b1; busy_len = 1;
    step(1);
    chk("w1_rinc", 32'(rinc), 32'd1);
    chk("w1_txv", 32'(tx_valid), 32'd1);
    chk("w1_data", 32'(tx_data), 32'hA5);
    step(1);
    chk("w1_rinc_pulse", 32'(rinc), 32'd0);
    chk("w1_txv_pulse", 32'(tx_valid), 32'd0);
    busy_len = 5;
    step(3);
    chk("w2_rinc", 32'(rinc), 32'd1);
    chk("w2_data", 32'(tx_data), 32'h3C);
    chk("w2_cnt_before", 32'(sent_cnt), 32'd1);
    step(10);
    chk("w2_cnt", 32'(sent_cnt), 32'd2);
    chk("w2_empty", 32'(rempty), 32'd1);
    chk("w2_rinc_cnt", 32'(rinc_cnt), 32'd2);
    chk("w2_txv_cnt", 32'(txv_cnt), 32'd2);
    chk("w2_log0", 32'(log_data[0]), 32'hA5);
    chk("w2_log1", 32'(log_data[1]), 32'h3C);

    // en low: no drain for 20 cycles, then pop on the next edge.
    en = 1'b0; busy_len = 1; push(8'h55);
    step(20);
    chk("en0_rinc_cnt", 32'(rinc_cnt), 32'd2);
    chk("en0_txv_cnt", 32'(txv_cnt), 32'd2);
    en = 1'b1;
    step(1);
    chk("en1_rinc", 32'(rinc), 32'd1);
    chk("en1_data", 32'(tx_data), 32'h55);
    step(6);
    chk("en1_cnt", 32'(sent_cnt), 32'd3);
    en = 1'b0;

    // Timeout: consumer never busy.
    busy_len = 0; push(8'h11); push(8'h22); en = 1'b1;
    step(16);
    chk("tmo_early", 32'(err_timeout), 32'd0);
    step(1);
    chk("tmo_set", 32'(err_timeout), 32'd1);
    step(1);
    chk("tmo_next_rinc", 32'(rinc), 32'd1);
    chk("tmo_next_data", 32'(tx_data), 32'h22);
    step(2);
    err_clr = 1'b1;
    step(1);
    chk("tmo_clr", 32'(err_timeout), 32'd0);
    err_clr = 1'b0;
    step(12);
    err_clr = 1'b1;
    step(1);
    chk("tmo_clr_prio", 32'(err_timeout), 32'd0);
    err_clr = 1'b0;
    step(1);
    chk("tmo_clr_prio_after", 32'(err_timeout), 32'd0);
    chk("tmo_cnt_kept", 32'(sent_cnt), 32'd3);
    chk("tmo_empty", 32'(rempty), 32'd1);

    // Reset while in WAIT_DONE with the consumer busy.
    busy_len = 10; push(8'h77); push(8'h88);
    step(4);
    base_rinc = rinc_cnt;
    rrst_n = 1'b0;
    step(1);
    chk("mrst_rinc", 32'(rinc), 32'd0);
    chk("mrst_txv", 32'(tx_valid), 32'd0);
    chk("mrst_txdata", 32'(tx_data), 32'd0);
    chk("mrst_cnt", 32'(sent_cnt), 32'd0);
    chk("mrst_busy_in", 32'(tx_busy), 32'd1);
    step(2);
    chk("mrst_no_pop", 32'(rinc_cnt), 32'(base_rinc));
    rrst_n = 1'b1; busy_len = 1;
    step(1);
    chk("mrst_first_rinc", 32'(rinc), 32'd1);
    chk("mrst_first_data", 32'(tx_data), 32'h88);
    step(5);
    chk("mrst_cnt_after", 32'(sent_cnt), 32'd1);

    // 17 back-to-back words through a 4-bit counter.
    rrst_n = 1'b0;
    step(2);
    base_rinc = rinc_cnt; base_txv = txv_cnt;
    for (int i = 0; i < 17; i++) push(8'(i * 3 + 1));
    rrst_n = 1'b1;
    step(80);
    chk("wrap_cnt", 32'(sent_cnt), 32'd1);
    chk("wrap_rinc", 32'(rinc_cnt - base_rinc), 32'd17);
    chk("wrap_txv", 32'(txv_cnt - base_txv), 32'd17);
    chk("wrap_last", 32'(log_data[(txv_cnt - 1) % 64]), 32'd49);
    chk("wrap_empty", 32'(rempty), 32'd1);

    chk("never_pop_empty", 32'(pop_empty), 32'd0);
    chk("rinc_gap_ge3", 32'(min_gap >= 3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side drain controller for the asynchronous FIFO, in the FIFO read-clock domain. Pops one word at a time when the FIFO is not empty and presents it to a busy-handshaked serial consumer (UART TX style) as a one-cycle valid pulse. Waits for the consumer to accept and finish before the next pop. Adds a busy-acknowledge timeout with a sticky error flag, and a count of words delivered.

## Interface
Parameters:
- DATA_WIDTH, 8, width of FIFO read data and consumer data
- TIMEOUT, 16, cycles allowed in WAIT_BUSY for tx_busy to rise; must be ≥2
- CNT_WIDTH, 16, width of the delivered-word counter

Ports (one clock; reset is synchronous and active-low):
- rclk  in  1  read-domain clock; all logic on rising edge
- rrst_n  in  1  synchronous active-low reset
- en  in  1  drain enable; level-sensitive
- rempty  in  1  FIFO empty flag from the FIFO read side
- rdata  in  DATA_WIDTH  FIFO read data; valid while rempty=0
- rinc  out  1  FIFO pop strobe; one-cycle pulse
- tx_data  out  DATA_WIDTH  word presented to the consumer; held until the next pop
- tx_valid  out  1  one-cycle pulse; tx_data is valid in the same cycle
- tx_busy  in  1  consumer busy; rises after accepting, falls when done
- err_clr  in  1  clears err_timeout
- err_timeout  out  1  sticky; set when tx_busy fails to rise within TIMEOUT
- sent_cnt  out  CNT_WIDTH  number of words accepted by the consumer; wraps

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If en=1 and rempty=0: capture rdata into tx_data, set rinc=1 and tx_valid=1 (registered), go to SEND.
  - Otherwise stay in IDLE.
- SEND: rinc and tx_valid are high during this cycle only. Clear the timeout counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1: sent_cnt += 1 (mod 2^CNT_WIDTH), go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 with tx_busy still 0: set err_timeout, go to IDLE. The word is dropped and not retried.
- WAIT_DONE: when tx_busy=0, go to IDLE.
- en affects only the IDLE decision. Deasserting en mid-transfer does not abort the transfer; it completes.
- err_timeout: sticky until err_clr=1. Clear has priority over set in the same cycle.
- tx_data changes only on the IDLE→SEND edge.
- Exactly one rinc per tx_valid. Never pop when rempty=1.
- Reset (rrst_n=0 at a clock edge), including mid-transfer:
  - state goes to IDLE
  - rinc, tx_valid, err_timeout are 0
  - tx_data and sent_cnt are 0
  - timeout counter is 0
  - No pop is issued in the reset cycle.

## Timing
- All outputs are registered; no combinational path from input to output.
- Pop latency: rempty falls with en=1 at edge N → rinc/tx_valid high in cycle N+1, for one cycle only.
- The FIFO empty flag is updated one cycle after a pop, because the Gray pointer is registered behind the binary pointer. The controller therefore guarantees at least 3 cycles between rinc pulses: SEND, ≥1 cycle WAIT_BUSY, ≥1 cycle WAIT_DONE.
- Fastest cycle per word: 4 clocks (IDLE, SEND, WAIT_BUSY, WAIT_DONE), given tx_busy high for exactly 1 cycle at the first WAIT_BUSY cycle.
- If tx_busy is already high on entry to WAIT_BUSY, it is treated as acceptance.
- Timeout: err_timeout is set TIMEOUT cycles after SEND.

## Structure
- Package fifo_rd_ctrl_pkg holds:
  - the state enum (2-bit: IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3)
  - the default parameter constants
- Single module. The timeout counter is inline, with width $clog2(TIMEOUT). No sub-module.

## Test plan
- Reset mid-WAIT_DONE with tx_busy=1 → next cycle state=IDLE and all outputs 0. After release with FIFO non-empty, the first rinc comes 1 cycle after the first rrst_n=1 edge.
- FIFO holds 0xA5, 0x3C; en=1; consumer busy for 1 cycle then 5 cycles → tx_data 0xA5 then 0x3C, two tx_valid pulses, two rinc pulses ≥3 cycles apart, sent_cnt=2, FIFO empty.
- en=0 with FIFO non-empty for 20 cycles → no rinc and no tx_valid. Raise en → pop within 1 cycle.
- tx_busy held 0 after tx_valid, TIMEOUT=16 → err_timeout=1 at 16 cycles after SEND, return to IDLE, next word popped. err_clr pulse → err_timeout=0.
- err_clr and a timeout in the same cycle → err_timeout stays 0.
- sent_cnt with CNT_WIDTH=4: deliver 17 words → sent_cnt=1 (wrap); rinc count is 17.
